// File: rtl/lsu_stage.sv
// lsu_stage: RV32I memory stage. ALU ops retire 1 cycle after accept; loads/stores hold mem_stall while dbus_req waits for ack or timeout.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses; the default build masks the low address bits instead.
module lsu_stage #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [4:0]        ex_rd,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_store_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [2:0]        ex_funct3,
   input  logic              ex_wr_enable,
   output logic              mem_stall,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [31:0]       dbus_wdata,
   output logic [3:0]        dbus_be,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata,
   output logic              mem_valid,
   output logic [4:0]        mem_rd,
   output logic [31:0]       mem_result,
   output logic              mem_wr_enable,
   output logic              mem_bus_err
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_BUS} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [4:0]       r_rd;
   logic             r_wr_en;
   logic             r_load;
   logic [1:0]       r_lane;
   logic [1:0]       r_size;
   logic             r_uns;

   logic             w_is_mem;
   logic [1:0]       w_lane;
   logic             w_b;
   logic             w_h;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load_data;

   // Size comes from funct3[1:0] alone: 00=B, 01=H, anything else is a word.
   always_comb begin
      w_is_mem = ex_mem_read | ex_mem_write;
      w_lane   = ex_alu_result[1:0];
      w_b      = (ex_funct3[1:0] == 2'b00);
      w_h      = (ex_funct3[1:0] == 2'b01);
      w_addr   = {ex_alu_result[ADDR_W-1:2], 2'b00};
      if (w_b) begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{ex_store_data[7:0]}};
      end else if (w_h) begin
         w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{ex_store_data[15:0]}};
      end else begin
         w_be    = 4'b1111;
         w_wdata = ex_store_data;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic w_misalign;
   assign w_misalign = (w_h & w_lane[0]) | (!w_b & !w_h & (w_lane != 2'b00));
`endif

   always_comb begin
      case (r_lane)
         2'd0:    w_byte = dbus_rdata[7:0];
         2'd1:    w_byte = dbus_rdata[15:8];
         2'd2:    w_byte = dbus_rdata[23:16];
         default: w_byte = dbus_rdata[31:24];
      endcase
      w_half = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      case (r_size)
         2'b00:   w_load_data = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load_data = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load_data = dbus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_rd          <= '0;
         r_wr_en       <= 1'b0;
         r_load        <= 1'b0;
         r_lane        <= '0;
         r_size        <= '0;
         r_uns         <= 1'b0;
         mem_stall     <= 1'b0;
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_addr     <= '0;
         dbus_wdata    <= '0;
         dbus_be       <= '0;
         mem_valid     <= 1'b0;
         mem_rd        <= '0;
         mem_result    <= '0;
         mem_wr_enable <= 1'b0;
         mem_bus_err   <= 1'b0;
      end else begin
         mem_valid     <= 1'b0;
         mem_wr_enable <= 1'b0;
         mem_bus_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ex_valid) begin
                  if (!w_is_mem) begin
                     mem_valid     <= 1'b1;
                     mem_rd        <= ex_rd;
                     mem_result    <= ex_alu_result;
                     mem_wr_enable <= ex_wr_enable & (ex_rd != 5'd0);
                  end
`ifdef MISALIGN_TRAP_EN
                  else if (w_misalign) begin
                     mem_valid   <= 1'b1;
                     mem_rd      <= ex_rd;
                     mem_result  <= ex_alu_result;
                     mem_bus_err <= 1'b1;
                  end
`endif
                  else begin
                     r_state    <= S_BUS;
                     r_cnt      <= '0;
                     r_rd       <= ex_rd;
                     r_wr_en    <= ex_wr_enable;
                     r_load     <= ex_mem_read;
                     r_lane     <= w_lane;
                     r_size     <= ex_funct3[1:0];
                     r_uns      <= ex_funct3[2];
                     mem_stall  <= 1'b1;
                     dbus_req   <= 1'b1;
                     dbus_we    <= !ex_mem_read;
                     dbus_addr  <= w_addr;
                     dbus_wdata <= w_wdata;
                     dbus_be    <= w_be;
                  end
               end
            end
            S_BUS: begin
               // Ack is checked first so an ack on the final cycle still completes normally.
               if (dbus_ack) begin
                  r_state       <= S_IDLE;
                  mem_stall     <= 1'b0;
                  dbus_req      <= 1'b0;
                  mem_valid     <= 1'b1;
                  mem_rd        <= r_rd;
                  mem_result    <= r_load ? w_load_data : 32'd0;
                  mem_wr_enable <= r_load & r_wr_en & (r_rd != 5'd0);
               end else if (r_cnt == CNT_LAST) begin
                  r_state     <= S_IDLE;
                  mem_stall   <= 1'b0;
                  dbus_req    <= 1'b0;
                  mem_valid   <= 1'b1;
                  mem_rd      <= r_rd;
                  mem_result  <= 32'd0;
                  mem_bus_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit forming the memory stage of the 5-stage RV32I pipeline.
- Consumes the registered execute-stage outputs and drives the data bus with a req/ack handshake.
- Aligns and sign-extends load data and produces the rd/result/write-enable bundle consumed by writeback.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles in BUS state before abort (min 2).
- ADDR_W, 32: data bus address width; lower bits come from ex_alu_result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute bundle valid.
- ex_rd  in  5  destination register.
- ex_alu_result  in  32  ALU result / effective address.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store; ex_mem_read has priority if both are set.
- ex_funct3  in  3  access size/sign.
- ex_wr_enable  in  1  instruction writes rd.
- mem_stall  out  1  upstream must hold its bundle.
- dbus_req  out  1  bus request, held until ack.
- dbus_we  out  1  1 = write.
- dbus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- dbus_wdata  out  32  lane-replicated store data.
- dbus_be  out  4  byte enables.
- dbus_ack  in  1  transaction complete; read data valid this cycle.
- dbus_rdata  in  32  read data.
- mem_valid  out  1  writeback bundle valid.
- mem_rd  out  5  to writeback.
- mem_result  out  32  load data or passed-through ALU result.
- mem_wr_enable  out  1  register-file write.
- mem_bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
Reset:
- All outputs 0; state IDLE; timeout counter 0.
- Reset asserted mid-transaction drops dbus_req immediately; the transaction is abandoned with no writeback.

States:
- IDLE
  - Accept when ex_valid=1.
  - Non-memory op: next cycle mem_valid=1, mem_result=ex_alu_result, mem_rd=ex_rd, mem_wr_enable=ex_wr_enable & (ex_rd!=0). Latency 1.
  - Memory op: latch address/data/funct3/rd; go to BUS; mem_valid=0 next cycle.
  - ex_valid=0: mem_valid=0 next cycle.
- BUS
  - dbus_req=1 with stable dbus_we/addr/wdata/be; mem_stall=1 (registered, equals state==BUS); counter increments each cycle.
  - dbus_ack=1: go to IDLE.
    - Next cycle mem_valid=1.
    - Load: mem_wr_enable = latched wr_enable & rd!=0; mem_result = extracted data.
    - Store: mem_wr_enable=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop req, go to IDLE, then next cycle mem_valid=1, mem_wr_enable=0, mem_bus_err=1 for one cycle.
  - Ack in the same cycle as timeout: ack wins, no error.

Memory op latency: req asserted cycle N+1 after accept at N; ack at N+1+k; result at N+2+k; next accept possible at N+2+k.

Sizes (lane = addr[1:0]):
- funct3 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- Load funct3 011/110/111 are treated as W.
- Store funct3 with [1:0]=11 is treated as W.
- Store byte enables: B = 1 << lane; H = 0011 << lane[1]*2; W = 1111.
- Store wdata: byte replicated ×4, half ×2.
- Loads: select lane byte/half from dbus_rdata; sign-extend for B/H, zero-extend for BU/HU.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - H access with addr[0]=1, or W access with addr[1:0]!=0, issues no bus request.
  - Stays IDLE; next cycle mem_valid=1, mem_wr_enable=0, mem_bus_err=1.
  - mem_result = faulting address.
- Undefined: misaligned low bits are masked (H uses addr[1], W uses lane 0) and the access proceeds normally.

Test Plan:
- Reset held low with dbus_ack toggling → all outputs 0; release → mem_stall=0, dbus_req=0.
- ADD bundle, rd=5, alu=0x1234 → one cycle later mem_valid=1, mem_result=0x1234, mem_wr_enable=1; with rd=0 → mem_wr_enable=0.
- LB addr 0x103, ack after 3 cycles with rdata 0x80FF_FF00 → dbus_addr=0x100, stall 4 cycles, mem_result=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x202, data 0x0000_BEEF → dbus_we=1, dbus_be=1100, dbus_wdata=0xBEEF_BEEF, mem_wr_enable=0.
- LW with no ack, TIMEOUT_CYCLES=8 → req drops after 8 cycles, mem_bus_err pulses once; repeat with ack on the 8th cycle → normal completion, no error.
- LW addr 0x101: with MISALIGN_TRAP_EN → no dbus_req, mem_bus_err=1, mem_result=0x101; without → dbus_addr=0x100, dbus_be=1111.
